// File: rtl/exc_ctrl.sv
// CPU-side exception sequencer: detects SYSCALL/BREAK/TEQ/ERET, drives the CP0 trap
// interface, stalls the datapath and issues a one-cycle PC redirect. Optional EXC_CTRL_EXT_INT_EN adds ext_int.
module exc_ctrl #(
  parameter logic [31:0] EPC_OFFSET = 32'd0,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             is_syscall,
  input  logic             is_break,
  input  logic             is_teq,
  input  logic             teq_equal,
  input  logic             is_eret,
  input  logic [31:0]      pc,
  input  logic [31:0]      status,
  input  logic [31:0]      exc_addr,
`ifdef EXC_CTRL_EXT_INT_EN
  input  logic             ext_int,
`endif
  output logic             stall,
  output logic             exception,
  output logic             eret,
  output logic [4:0]       cause,
  output logic [31:0]      epc_out,
  output logic             pc_redirect,
  output logic [31:0]      redirect_addr,
  output logic             busy,
  output logic [CNT_W-1:0] trap_count
);

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [4:0] CAUSE_INT     = 5'b00000;

  typedef enum logic [1:0] {IDLE, TRAP, ERETS, REDIR} state_t;

  state_t           state, next_state;
  logic [4:0]       cause_r, cause_d;
  logic [31:0]      epc_r, epc_d;
  logic [31:0]      redirect_r;
  logic [CNT_W-1:0] count_r;

  logic idle;
  logic sys_en, brk_en, teq_en, any_trap;
  logic take_trap, take_eret, take_int, take;

  assign idle = (state == IDLE);

  // Each trap needs the global enable plus its own mask bit.
  assign sys_en   = status[0] & status[1] & is_syscall;
  assign brk_en   = status[0] & status[2] & is_break;
  assign teq_en   = status[0] & status[3] & is_teq & teq_equal;
  assign any_trap = sys_en | brk_en | teq_en;

  assign take_trap = ~rst & inst_valid & idle & any_trap;
  assign take_eret = ~rst & inst_valid & idle & is_eret & ~any_trap;

`ifdef EXC_CTRL_EXT_INT_EN
  logic int_meta, int_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= ext_int;
      int_sync <= int_meta;
    end
  end

  assign take_int = ~rst & idle & int_sync & status[0] & status[4] & ~take_trap & ~take_eret;

  logic unused_status;
  assign unused_status = ^status[31:5];
`else
  assign take_int = 1'b0;

  logic unused_status;
  assign unused_status = ^status[31:4];
`endif

  assign take = take_trap | take_eret | take_int;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    cause_d    = cause_r;
    epc_d      = epc_r;
    unique case (state)
      IDLE: begin
        if (take_trap) begin
          next_state = TRAP;
          epc_d      = pc + EPC_OFFSET;
          if (sys_en)      cause_d = CAUSE_SYSCALL;
          else if (brk_en) cause_d = CAUSE_BREAK;
          else             cause_d = CAUSE_TEQ;
        end else if (take_eret) begin
          next_state = ERETS;
        end else if (take_int) begin
          next_state = TRAP;
          cause_d    = CAUSE_INT;
          epc_d      = pc;
        end
      end
      TRAP:    next_state = REDIR;
      ERETS:   next_state = REDIR;
      REDIR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_r    <= '0;
      epc_r      <= '0;
      redirect_r <= '0;
      count_r    <= '0;
    end else begin
      cause_r <= cause_d;
      epc_r   <= epc_d;
      // CP0 presents the vector during TRAP and the saved EPC during ERETS.
      if (state == TRAP || state == ERETS) redirect_r <= exc_addr;
      if (state == TRAP && count_r != {CNT_W{1'b1}}) count_r <= count_r + CNT_W'(1);
    end
  end

  assign busy          = ~idle;
  assign stall         = take | ~idle;
  assign exception     = (state == TRAP);
  assign eret          = (state == ERETS);
  assign pc_redirect   = (state == REDIR);
  assign cause         = (state == TRAP) ? cause_r : 5'b0;
  assign epc_out       = (state == TRAP) ? epc_r : 32'b0;
  assign redirect_addr = redirect_r;
  assign trap_count    = count_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: trap/ERET sequencing, masking, priority, reset abort,
// back-to-back requests and counter saturation (second instance with CNT_W=2).
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, is_syscall, is_break, is_teq, teq_equal, is_eret;
  logic [31:0] pc, status, exc_addr;

  logic        stall, exception, eret, pc_redirect, busy;
  logic [4:0]  cause;
  logic [31:0] epc_out, redirect_addr;
  logic [7:0]  trap_count;

  logic        stall2, exception2, eret2, pc_redirect2, busy2;
  logic [4:0]  cause2;
  logic [31:0] epc_out2, redirect_addr2;
  logic [1:0]  trap_count2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_equal(teq_equal), .is_eret(is_eret),
    .pc(pc), .status(status), .exc_addr(exc_addr),
    .stall(stall), .exception(exception), .eret(eret), .cause(cause), .epc_out(epc_out),
    .pc_redirect(pc_redirect), .redirect_addr(redirect_addr), .busy(busy),
    .trap_count(trap_count)
  );

  exc_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_equal(teq_equal), .is_eret(is_eret),
    .pc(pc), .status(status), .exc_addr(exc_addr),
    .stall(stall2), .exception(exception2), .eret(eret2), .cause(cause2), .epc_out(epc_out2),
    .pc_redirect(pc_redirect2), .redirect_addr(redirect_addr2), .busy(busy2),
    .trap_count(trap_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    inst_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_equal = 0; is_eret = 0;
  endtask

  // Present one instruction for the current cycle; flags = {syscall, break, teq, teq_equal, eret}.
  task automatic req(input logic [4:0] flags, input logic [31:0] p);
    inst_valid = 1;
    {is_syscall, is_break, is_teq, teq_equal, is_eret} = flags;
    pc = p;
    #1;
  endtask

  // Full trap sequence from request cycle through REDIR.
  task automatic run_trap(input string tag, input logic [4:0] flags, input logic [31:0] p,
                          input logic [4:0] exp_cause);
    req(flags, p);
    check({tag, "_req_stall"}, {31'b0, stall}, 32'd1);
    step();
    clear_req();
    check({tag, "_exception"}, {31'b0, exception}, 32'd1);
    check({tag, "_cause"}, {27'b0, cause}, {27'b0, exp_cause});
    check({tag, "_epc"}, epc_out, p);
    step();
    check({tag, "_redirect"}, {31'b0, pc_redirect}, 32'd1);
    check({tag, "_redir_addr"}, redirect_addr, 32'h0040_0004);
    check({tag, "_cause_cleared"}, {27'b0, cause}, 32'd0);
  endtask

  initial begin
    rst = 1; clear_req(); pc = 0; status = 0; exc_addr = 32'h0040_0004;
    #12;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_count", {24'b0, trap_count}, 32'd0);
    check("rst_redir_addr", redirect_addr, 32'd0);
    rst = 0;
    step();

    // SYSCALL taken
    status = 32'h0000_000F;
    run_trap("sys", 5'b10000, 32'h0040_0100, 5'b01000);
    check("sys_count", {24'b0, trap_count}, 32'd1);
    step();
    check("sys_idle_stall", {31'b0, stall}, 32'd0);
    check("sys_hold_addr", redirect_addr, 32'h0040_0004);

    // BREAK masked
    status = 32'h0000_000B;
    req(5'b01000, 32'h0040_0200);
    check("brk_mask_stall", {31'b0, stall}, 32'd0);
    step();
    clear_req();
    check("brk_mask_exc", {31'b0, exception}, 32'd0);
    check("brk_mask_busy", {31'b0, busy}, 32'd0);
    check("brk_mask_count", {24'b0, trap_count}, 32'd1);

    // TEQ not equal, then equal
    status = 32'h0000_000F;
    req(5'b00100, 32'h0040_0300);
    check("teq_ne_stall", {31'b0, stall}, 32'd0);
    step();
    clear_req();
    check("teq_ne_busy", {31'b0, busy}, 32'd0);
    run_trap("teq", 5'b00110, 32'h0040_0304, 5'b01101);
    check("teq_count", {24'b0, trap_count}, 32'd2);
    step();

    // ERET: stall held for three cycles
    exc_addr = 32'h0040_0104;
    req(5'b00001, 32'h0040_0400);
    check("eret_req_stall", {31'b0, stall}, 32'd1);
    step();
    clear_req();
    check("eret_pulse", {31'b0, eret}, 32'd1);
    check("eret_no_exc", {31'b0, exception}, 32'd0);
    check("eret_stall2", {31'b0, stall}, 32'd1);
    step();
    check("eret_redirect", {31'b0, pc_redirect}, 32'd1);
    check("eret_addr", redirect_addr, 32'h0040_0104);
    check("eret_pulse_done", {31'b0, eret}, 32'd0);
    check("eret_stall3", {31'b0, stall}, 32'd1);
    step();
    check("eret_stall_end", {31'b0, stall}, 32'd0);
    check("eret_count", {24'b0, trap_count}, 32'd2);

    // Priority (all flags set -> SYSCALL), then back-to-back BREAK in the next IDLE cycle
    exc_addr = 32'h0040_0004;
    run_trap("prio", 5'b11111, 32'h0040_0500, 5'b01000);
    step();
    run_trap("b2b", 5'b01000, 32'h0040_0504, 5'b01001);
    check("b2b_count", {24'b0, trap_count}, 32'd4);
    step();

    // Global enable clear blocks traps
    status = 32'h0000_000E;
    req(5'b10000, 32'h0040_0600);
    check("glob_mask_stall", {31'b0, stall}, 32'd0);
    step();
    clear_req();
    check("glob_mask_busy", {31'b0, busy}, 32'd0);

    // Reset during TRAP aborts the sequence
    status = 32'h0000_000F;
    req(5'b10000, 32'h0040_0700);
    step();
    clear_req();
    check("abort_in_trap", {31'b0, exception}, 32'd1);
    rst = 1;
    #1;
    check("abort_exc", {31'b0, exception}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_epc", epc_out, 32'd0);
    check("abort_count", {24'b0, trap_count}, 32'd0);
    step();
    rst = 0;
    check("abort_no_redirect", {31'b0, pc_redirect}, 32'd0);
    step();
    check("abort_no_redirect2", {31'b0, pc_redirect}, 32'd0);

    // Five traps: the 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      req(5'b10000, 32'h0040_0800 + 32'(i * 4));
      step();
      clear_req();
      step();
      step();
    end
    check("sat_count2", {30'b0, trap_count2}, 32'd3);
    check("sat_count8", {24'b0, trap_count}, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- CPU-side initiator of the CP0 exception interface; drives CP0's `exception`/`eret`/`cause`/`pc` inputs and consumes its `status`/`exc_addr` outputs.
- Detects SYSCALL, BREAK, TEQ-taken and ERET from decode, gates traps by the CP0 status mask, and stalls the datapath.
- Sequences the CP0 update, then issues a one-cycle PC redirect to the vector or the saved EPC.
- Sits between the decoder/PC logic and CP0 in the single-cycle/multi-cycle CPU54 core.

Parameters:
- EPC_OFFSET, 32'd0, constant added to the sampled pc to form `epc_out`.
- CNT_W, 8, width of the saturating trap counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- inst_valid  input  1  decoded instruction valid this cycle
- is_syscall  input  1  instruction is SYSCALL
- is_break  input  1  instruction is BREAK
- is_teq  input  1  instruction is TEQ
- teq_equal  input  1  TEQ operands equal
- is_eret  input  1  instruction is ERET
- pc  input  32  pc of current instruction
- status  input  32  CP0 status register
- exc_addr  input  32  CP0 exception/return address
- stall  output  1  hold PC/register writes
- exception  output  1  to CP0: enter trap (1-cycle pulse)
- eret  output  1  to CP0: exception return (1-cycle pulse)
- cause  output  5  to CP0: exception code
- epc_out  output  32  to CP0 pc input
- pc_redirect  output  1  load redirect_addr into PC (1-cycle pulse)
- redirect_addr  output  32  target PC
- busy  output  1  FSM not IDLE
- trap_count  output  CNT_W  traps taken, saturating

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
  - Reset forces state IDLE; all outputs and internal registers are 0.
  - An assertion mid-sequence aborts immediately: no pulse completes and stall drops.
- Cause codes: SYSCALL=5'b01000, BREAK=5'b01001, TEQ=5'b01101.
- Enable rule: a trap is taken only if `status[0]` is 1 AND its mask bit is 1.
  - Mask bits: `status[1]` SYSCALL, `status[2]` BREAK, `status[3]` TEQ.
  - A masked trap, or TEQ with `teq_equal`=0, executes as a NOP: no stall, no count.
- ERET is always taken.
- Priority when several flags are set: SYSCALL > BREAK > TEQ > ERET.
- take = `inst_valid` & state==IDLE & (enabled trap | `is_eret`).
- `stall` = take | (state!=IDLE), combinational. `busy` = state!=IDLE.
- FSM states:
  - IDLE, on take with a trap:
    - Go to TRAP.
    - Latch `cause` and `epc_out` = `pc` + EPC_OFFSET (32-bit wrap).
  - IDLE, on take with ERET: go to ERETS.
  - TRAP (1 cycle):
    - `exception`=1; `cause` and `epc_out` held.
    - Capture `exc_addr` (CP0 drives the vector 0x00400004 here) into `redirect_addr`.
    - `trap_count` increments, saturating at all-ones.
    - Go to REDIR.
  - ERETS (1 cycle):
    - `eret`=1.
    - Capture `exc_addr` (CP0 EPC) into `redirect_addr`.
    - Go to REDIR.
  - REDIR (1 cycle):
    - `pc_redirect`=1 with `redirect_addr` stable.
    - Go to IDLE.
- Latency: request cycle, then 2 busy cycles; the PC loads at the end of REDIR.
- Output hold rules:
  - `cause`/`epc_out` are 0 outside TRAP.
  - `exception`/`eret`/`pc_redirect` are never high together and never high for 2 consecutive cycles.
  - `redirect_addr` holds its last value after REDIR.
- Inputs are ignored while not IDLE; upstream holds the instruction via `stall`.
- Back-to-back: a new request in the IDLE cycle immediately after REDIR is accepted normally.

Optional Feature:
- Macro: EXC_CTRL_EXT_INT_EN.
- Defined:
  - Adds input `ext_int` (1 bit, asynchronous level) with a 2-flop synchronizer.
  - In IDLE with no instruction trap or ERET taken, the synchronized `ext_int` with `status[0]`=1 and `status[4]`=1 is taken as a trap.
  - Uses cause 5'b00000 and `epc_out` = `pc` (interrupted instruction not executed); same TRAP/REDIR sequence; counted.
  - Instruction traps and ERET take priority over the interrupt.
- Undefined: no `ext_int` port; interrupts are never taken.

Test Plan:
- status=0x0000000F, SYSCALL at pc=0x00400100 → next cycle exception=1, cause=01000, epc_out=0x00400100; following cycle pc_redirect=1, redirect_addr=0x00400004; trap_count=1.
- status=0x0000000B (BREAK masked), BREAK → stall=0, no pulses, trap_count unchanged.
- TEQ with teq_equal=0, then teq_equal=1, status=0x0F → first ignored; second gives cause=01101.
- ERET with CP0 exc_addr=0x00400104 → eret=1 for 1 cycle, then pc_redirect=1, redirect_addr=0x00400104; stall high for 3 cycles total.
- rst asserted during TRAP → state IDLE and all outputs 0 immediately; no pc_redirect follows.
- CNT_W=2, 5 taken traps → trap_count saturates at 3.
